// File: rtl/drr_arbiter.sv
// Deficit-round-robin scheduler: visits queues in turn, credits QUANTUM bytes per visit and
// offers one head-of-line packet at a time; each accepted grant pulses cng_* so the source refreshes that head.
module drr_arbiter #(
    parameter int PKT_QS_CNT = 4,
    parameter int QUANTUM    = 500,
    parameter int DEF_W      = 17
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [PKT_QS_CNT-1:0][15:0]         size_i,
    input  logic [PKT_QS_CNT-1:0]               size_val_i,
    output logic [$clog2(PKT_QS_CNT)-1:0]       cng_addr_o,
    output logic                                cng_val_o,
    output logic [$clog2(PKT_QS_CNT)-1:0]       grant_q_o,
    output logic [15:0]                         grant_size_o,
    output logic                                grant_val_o,
    input  logic                                grant_rdy_i
);

    localparam int AW = $clog2(PKT_QS_CNT);

    typedef enum logic [2:0] {
        IDLE,
        VISIT,
        CHECK,
        GRANT,
        REFILL
    } state_t;

    state_t                             state_q;
    logic [AW-1:0]                      ptr_q;
    logic [AW-1:0]                      ptr_d;
    logic [PKT_QS_CNT-1:0][DEF_W-1:0]   deficit_q;

    logic [DEF_W-1:0]                   curDef;
    logic [DEF_W-1:0]                   defAdd_d;
    logic [DEF_W-1:0]                   defSub_d;
    logic [15:0]                        curSize;
    logic                               curVal;
    logic                               headFits;

    // Everything the FSM needs about the queue under the pointer.
    always_comb begin
        ptr_d    = (ptr_q == AW'(PKT_QS_CNT - 1)) ? '0 : ptr_q + 1'b1;
        curDef   = deficit_q[ptr_q];
        curSize  = size_i[ptr_q];
        curVal   = size_val_i[ptr_q];
        defAdd_d = curDef + DEF_W'(QUANTUM);
        defSub_d = curDef - DEF_W'(grant_size_o);
        headFits = (DEF_W'(curSize) <= curDef);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            deficit_q    <= '0;
            grant_val_o  <= 1'b0;
            grant_q_o    <= '0;
            grant_size_o <= '0;
            cng_val_o    <= 1'b0;
            cng_addr_o   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= VISIT;
                end

                VISIT: begin
                    if (!curVal) begin
                        deficit_q[ptr_q] <= '0;
                        ptr_q            <= ptr_d;
                    end else begin
                        deficit_q[ptr_q] <= defAdd_d;
                        state_q          <= CHECK;
                    end
                end

                // Re-entered from REFILL without a new quantum, so one visit can drain several packets.
                CHECK: begin
                    if (!curVal) begin
                        deficit_q[ptr_q] <= '0;
                        ptr_q            <= ptr_d;
                        state_q          <= VISIT;
                    end else if (headFits) begin
                        grant_q_o    <= ptr_q;
                        grant_size_o <= curSize;
                        grant_val_o  <= 1'b1;
                        state_q      <= GRANT;
                    end else begin
                        ptr_q   <= ptr_d;
                        state_q <= VISIT;
                    end
                end

                GRANT: begin
                    if (grant_rdy_i) begin
                        deficit_q[ptr_q] <= defSub_d;
                        grant_val_o      <= 1'b0;
                        cng_val_o        <= 1'b1;
                        cng_addr_o       <= ptr_q;
                        state_q          <= REFILL;
                    end
                end

                REFILL: begin
                    cng_val_o <= 1'b0;
                    state_q   <= CHECK;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
